// File: rtl/weyl_stream_ser.sv
// Quota-to-bitstream serialiser: drives a quota to an adjacent WEYL mask table, captures the mask,
// and streams it LSB-first over a valid/ready handshake, then checks the emitted ones-count.
module weyl_stream_ser #(
    parameter  int BITSTREAM = 64,
    localparam int QW        = $clog2(BITSTREAM) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 q_valid,
    output logic                 q_ready,
    input  logic [QW-1:0]        q_num,
    output logic [QW-1:0]        weyl_quota,
    input  logic [BITSTREAM-1:0] weyl_mask,
    input  logic                 abort,
    output logic                 bit_valid,
    input  logic                 bit_ready,
    output logic                 bit_out,
    output logic                 bit_last,
    output logic                 done,
    output logic [QW-1:0]        ones_cnt,
    output logic                 cnt_err
);

    localparam int BW = $clog2(BITSTREAM);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_STREAM = 2'd2
    } state_t;

    state_t               state_r;
    state_t               state_s;
    logic [BITSTREAM-1:0] shreg_r;
    logic [BW-1:0]        beat_r;
    logic [QW-1:0]        weyl_quota_r;
    logic [QW-1:0]        ones_cnt_r;
    logic                 done_r;
    logic                 cnt_err_r;

    logic                 accept_s;
    logic                 beat_hs_s;
    logic                 at_last_s;
    logic                 last_hs_s;
    logic [QW-1:0]        ones_next_s;

    // Requests above the stream length saturate to an all-ones stream.
    function automatic logic [QW-1:0] clamp_quota(input logic [QW-1:0] q);
        logic [QW-1:0] lim;
        lim = QW'(BITSTREAM);
        if (q > lim) begin
            return lim;
        end else begin
            return q;
        end
    endfunction

    function automatic logic [QW-1:0] add_bit(input logic [QW-1:0] cnt, input logic b);
        return cnt + {{(QW-1){1'b0}}, b};
    endfunction

    // Abort outranks every handshake, so it gates both the accept and the beat.
    always_comb begin
        accept_s    = (state_r == ST_IDLE) && q_valid && !abort;
        beat_hs_s   = (state_r == ST_STREAM) && bit_ready && !abort;
        at_last_s   = (beat_r == BW'(BITSTREAM - 1));
        last_hs_s   = beat_hs_s && at_last_s;
        ones_next_s = add_bit(ones_cnt_r, shreg_r[0]);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_s = state_r;
        if (abort) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (q_valid) begin
                        state_s = ST_LOAD;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    state_s = ST_STREAM;
                end
                ST_STREAM: begin
                    if (last_hs_s) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_STREAM;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // FSM outputs, decoded purely from registered state so they never depend on inputs.
    always_comb begin
        q_ready   = 1'b0;
        bit_valid = 1'b0;
        bit_out   = 1'b0;
        bit_last  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                q_ready = 1'b1;
            end
            ST_LOAD: begin
                q_ready = 1'b0;
            end
            ST_STREAM: begin
                bit_valid = 1'b1;
                bit_out   = shreg_r[0];
                bit_last  = at_last_s;
            end
            default: begin
                q_ready = 1'b0;
            end
        endcase
    end

    // Quota towards the mask table; it moves only on an accepted request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            weyl_quota_r <= {QW{1'b0}};
        end else if (accept_s) begin
            weyl_quota_r <= clamp_quota(q_num);
        end else begin
            weyl_quota_r <= weyl_quota_r;
        end
    end

    // Mask capture in LOAD, then one shift per accepted beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_r <= {BITSTREAM{1'b0}};
            beat_r  <= {BW{1'b0}};
        end else if (!abort && (state_r == ST_LOAD)) begin
            shreg_r <= weyl_mask;
            beat_r  <= {BW{1'b0}};
        end else if (beat_hs_s && !at_last_s) begin
            shreg_r <= {1'b0, shreg_r[BITSTREAM-1:1]};
            beat_r  <= beat_r + BW'(1);
        end else begin
            shreg_r <= shreg_r;
            beat_r  <= beat_r;
        end
    end

    // Ones tally: cleared on accept, held through aborts and until the next accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ones_cnt_r <= {QW{1'b0}};
        end else if (accept_s) begin
            ones_cnt_r <= {QW{1'b0}};
        end else if (beat_hs_s) begin
            ones_cnt_r <= ones_next_s;
        end else begin
            ones_cnt_r <= ones_cnt_r;
        end
    end

    // Completion pulse and sticky count check, both qualified by the final beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_r    <= 1'b0;
            cnt_err_r <= 1'b0;
        end else begin
            done_r <= last_hs_s;
            if (last_hs_s && (ones_next_s != weyl_quota_r)) begin
                cnt_err_r <= 1'b1;
            end else begin
                cnt_err_r <= cnt_err_r;
            end
        end
    end

    assign weyl_quota = weyl_quota_r;
    assign ones_cnt   = ones_cnt_r;
    assign done       = done_r;
    assign cnt_err    = cnt_err_r;

endmodule

// File: tb/tb_weyl_stream_ser.sv
// Bench for weyl_stream_ser: models the WEYL table (BASE=61, STRIDE=17) beside the DUT and checks
// every streamed beat, latency, saturation, backpressure, abort, reset and the sticky count error.
module tb_weyl_stream_ser;

    localparam int BS = 64;
    localparam int QW = 7;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          q_valid;
    logic          q_ready;
    logic [QW-1:0] q_num;
    logic [QW-1:0] weyl_quota;
    logic [BS-1:0] weyl_mask;
    logic          abort;
    logic          bit_valid;
    logic          bit_ready;
    logic          bit_out;
    logic          bit_last;
    logic          done;
    logic [QW-1:0] ones_cnt;
    logic          cnt_err;
    logic [BS-1:0] flip_mask;

    int total = 0;
    int bad   = 0;
    bit err_exp = 1'b0;

    weyl_stream_ser #(.BITSTREAM(BS)) dut (
        .clk(clk), .rst_n(rst_n), .q_valid(q_valid), .q_ready(q_ready), .q_num(q_num),
        .weyl_quota(weyl_quota), .weyl_mask(weyl_mask), .abort(abort), .bit_valid(bit_valid),
        .bit_ready(bit_ready), .bit_out(bit_out), .bit_last(bit_last), .done(done),
        .ones_cnt(ones_cnt), .cnt_err(cnt_err)
    );

    always #5 clk = ~clk;

    // WEYL table: the first q slots of the sequence (61 + 17k) mod 64 are set.
    function automatic logic [BS-1:0] weyl_ref(input int q);
        logic [BS-1:0] m;
        int n;
        m = '0;
        n = (q > BS) ? BS : q;
        for (int k = 0; k < n; k++) m[(61 + 17 * k) % BS] = 1'b1;
        return m;
    endfunction

    assign weyl_mask = weyl_ref(int'(weyl_quota)) ^ flip_mask;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_q_ready"}, q_ready, 1);
        check({tag, "_bit_valid"}, bit_valid, 0);
        check({tag, "_bit_out"}, bit_out, 0);
        check({tag, "_bit_last"}, bit_last, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_ones_cnt"}, ones_cnt, 0);
        check({tag, "_cnt_err"}, cnt_err, 0);
        check({tag, "_weyl_quota"}, weyl_quota, 0);
    endtask

    // One request/stream; abort_beat or rst_beat >= 0 cuts the stream at that beat.
    task automatic run_stream(input int q, input bit stall, input int abort_beat, input int rst_beat);
        logic [BS-1:0] exp_bits;
        int clamp, beat, ones, k;
        bit finished, was_stalled;
        clamp = (q > BS) ? BS : q;
        exp_bits = weyl_ref(q) ^ flip_mask;
        @(negedge clk);
        check("q_ready_idle", q_ready, 1);
        q_valid = 1'b1;
        q_num = q[QW-1:0];
        bit_ready = 1'b1;
        @(negedge clk);
        q_valid = 1'b0;
        check("weyl_quota", weyl_quota, clamp);
        check("load_bit_valid", bit_valid, 0);
        check("load_q_ready", q_ready, 0);
        beat = 0; ones = 0; k = 1; finished = 1'b0; was_stalled = 1'b0;
        while (!finished && k < 2000) begin
            @(negedge clk);
            k++;
            if (k == 2) check("first_valid", bit_valid, 1);
            if (!bit_valid) begin
                check("valid_drop", bit_valid, 1);
                return;
            end
            check(was_stalled ? "held_out" : "bit_out", bit_out, exp_bits[beat]);
            check(was_stalled ? "held_last" : "bit_last", bit_last, beat == BS - 1);
            check("done_mid", done, 0);
            if (beat == rst_beat) begin
                rst_n = 1'b0;
                #1;
                check_reset_vals("midrst");
                @(negedge clk);
                rst_n = 1'b1;
                err_exp = 1'b0;
                return;
            end
            if (beat == abort_beat) begin
                abort = 1'b1;
                bit_ready = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                check("abort_valid", bit_valid, 0);
                check("abort_q_ready", q_ready, 1);
                check("abort_done", done, 0);
                check("abort_ones", ones_cnt, ones);
                check("abort_err", cnt_err, err_exp);
                @(negedge clk);
                check("abort_no_done", done, 0);
                return;
            end
            bit_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bit_ready) begin
                ones += int'(exp_bits[beat]);
                if (beat == BS - 1) finished = 1'b1;
                beat++;
                was_stalled = 1'b0;
            end else begin
                was_stalled = 1'b1;
            end
        end
        if (!finished) begin
            check("stream_timeout", 0, 1);
            return;
        end
        @(negedge clk);
        bit_ready = 1'b1;
        check("done_pulse", done, 1);
        if (!stall) check("done_latency", k + 1, BS + 2);
        check("ones_cnt", ones_cnt, ones);
        check("done_q_ready", q_ready, 1);
        check("done_bit_valid", bit_valid, 0);
        if (ones != clamp) err_exp = 1'b1;
        check("cnt_err", cnt_err, err_exp);
        @(negedge clk);
        check("done_once", done, 0);
        check("ones_held", ones_cnt, ones);
    endtask

    initial begin
        rst_n = 1'b0; q_valid = 1'b0; abort = 1'b0; bit_ready = 1'b0;
        q_num = '0; flip_mask = '0;
        #1;
        check_reset_vals("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        run_stream(0, 1'b0, -1, -1);
        run_stream(2, 1'b0, -1, -1);
        run_stream(64, 1'b0, -1, -1);
        run_stream(100, 1'b0, -1, -1);
        run_stream(32, 1'b1, -1, -1);
        run_stream(10, 1'b0, 20, -1);
        run_stream(1, 1'b0, -1, -1);

        // Abort while a request is offered in IDLE must block the accept.
        @(negedge clk);
        q_valid = 1'b1; abort = 1'b1; q_num = 7'd9;
        @(negedge clk);
        q_valid = 1'b0; abort = 1'b0;
        check("idle_abort_quota", weyl_quota, 1);
        check("idle_abort_ready", q_ready, 1);
        @(negedge clk);
        check("idle_abort_valid", bit_valid, 0);

        run_stream(7, 1'b0, -1, 40);

        // Corrupted mask: extra one at bit 0, outside the q=5 pattern.
        flip_mask = 64'h1;
        run_stream(5, 1'b0, -1, -1);
        check("flip_err_set", cnt_err, 1);
        flip_mask = '0;
        run_stream(20, 1'b0, -1, -1);
        check("err_sticky", cnt_err, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("err_reset", cnt_err, 0);
        err_exp = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_stream(int'($urandom_range(0, 127)), 1'($urandom_range(0, 1)), -1, -1);
        end
        run_stream(int'($urandom_range(0, 64)), 1'b1, int'($urandom_range(0, 63)), -1);
        run_stream(int'($urandom_range(0, 64)), 1'b0, -1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
